// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - 6502-style CPU/SRAM phase enables, wait states, IRQ timers and NMI pulse.
// Optional single-step control: define CPU_PHASE_SEQUENCER_SINGLE_STEP_EN.
module cpu_phase_sequencer #(
  parameter int MEM_WAIT_STATES = 0,
  parameter int NUM_IRQ         = 2,
  parameter int PERIOD_W        = 16,
  parameter int CYCLE_W         = 32,
  parameter int NMI_LOW_CYCLES  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         stall,
  input  logic [NUM_IRQ*PERIOD_W-1:0]  irq_period,
  input  logic [NUM_IRQ-1:0]           irq_enable,
  input  logic [NUM_IRQ-1:0]           irq_ack,
  input  logic                         nmi_trigger,
`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
  input  logic                         step_mode,
  input  logic                         step,
`endif
  output logic                         enable_cpu_clk,
  output logic                         enable_sram_clk,
  output logic [CYCLE_W-1:0]           cycle_count,
  output logic [NUM_IRQ-1:0]           irq_pending,
  output logic                         irq_n,
  output logic                         nmi_n
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CPU  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_MEM  = 2'd3;

  localparam int WAIT_W = (MEM_WAIT_STATES > 1) ? $clog2(MEM_WAIT_STATES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (MEM_WAIT_STATES > 0) ? WAIT_W'(MEM_WAIT_STATES - 1) : '0;
  localparam int NMI_W = (NMI_LOW_CYCLES > 0) ? $clog2(NMI_LOW_CYCLES + 1) : 1;
  localparam logic [NMI_W-1:0] NMI_LOAD = NMI_W'(NMI_LOW_CYCLES);

  logic [1:0]          state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [PERIOD_W-1:0] irq_cnt_q [NUM_IRQ];
  logic [PERIOD_W-1:0] irq_cnt_d [NUM_IRQ];
  logic [NUM_IRQ-1:0]  pending_q, pending_d, irq_fire;
  logic                irq_n_q, irq_n_d;
  logic [NMI_W-1:0]    nmi_cnt_q, nmi_cnt_d;
  logic                nmi_trig_q, nmi_trig_d;
  logic                cpu_phase, start_req, continue_req;

  assign cpu_phase = (state_q == ST_CPU);

`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
  logic step_q, step_d;
  assign step_d       = step;
  assign start_req    = step_mode ? (step & ~step_q) : run;
  assign continue_req = run & ~step_mode;
`else
  assign start_req    = run;
  assign continue_req = run;
`endif

  // A started CPU/MEM pair always completes; run is only consulted at IDLE and MEM exit.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: if (start_req) state_d = ST_CPU;
      ST_CPU: begin
        if (MEM_WAIT_STATES > 0) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) state_d = ST_MEM;
        else wait_cnt_d = wait_cnt_q - WAIT_W'(1);
      end
      ST_MEM:  if (!stall) state_d = continue_req ? ST_CPU : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cycle_d = cycle_q;
    if (cpu_phase) cycle_d = cycle_q + CYCLE_W'(1);
  end

  // Counters compare live against the period, so a lowered period wraps through 2^PERIOD_W.
  always_comb begin
    irq_fire = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irq_cnt_d[i] = irq_cnt_q[i];
      if (!irq_enable[i]) begin
        irq_cnt_d[i] = '0;
      end else if (cpu_phase && (irq_period[i*PERIOD_W +: PERIOD_W] != '0)) begin
        if (irq_cnt_q[i] == irq_period[i*PERIOD_W +: PERIOD_W] - PERIOD_W'(1)) begin
          irq_fire[i]  = 1'b1;
          irq_cnt_d[i] = '0;
        end else begin
          irq_cnt_d[i] = irq_cnt_q[i] + PERIOD_W'(1);
        end
      end
    end
    pending_d = irq_fire | (pending_q & ~irq_ack);
    irq_n_d   = ~|pending_q;
  end

  always_comb begin
    nmi_trig_d = nmi_trigger;
    nmi_cnt_d  = nmi_cnt_q;
    if (nmi_trigger && !nmi_trig_q && (nmi_cnt_q == '0)) nmi_cnt_d = NMI_LOAD;
    else if (cpu_phase && (nmi_cnt_q != '0)) nmi_cnt_d = nmi_cnt_q - NMI_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      cycle_q    <= '0;
      pending_q  <= '0;
      irq_n_q    <= 1'b1;
      nmi_cnt_q  <= '0;
      nmi_trig_q <= 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) irq_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cycle_q    <= cycle_d;
      pending_q  <= pending_d;
      irq_n_q    <= irq_n_d;
      nmi_cnt_q  <= nmi_cnt_d;
      nmi_trig_q <= nmi_trig_d;
      for (int i = 0; i < NUM_IRQ; i++) irq_cnt_q[i] <= irq_cnt_d[i];
    end
  end

`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step_d;
  end
`endif

  assign enable_cpu_clk  = cpu_phase;
  assign enable_sram_clk = (state_q == ST_MEM) & ~stall;
  assign cycle_count     = cycle_q;
  assign irq_pending     = pending_q;
  assign irq_n           = irq_n_q;
  assign nmi_n           = (nmi_cnt_q == '0);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb/tb_cpu_phase_sequencer.sv - self-checking bench for cpu_phase_sequencer (two wait-state configurations).
module tb_cpu_phase_sequencer;
  localparam int NI  = 2;
  localparam int PW  = 16;
  localparam int MWS = 2;
  localparam int NMI_LOW = 4;

  logic clk, reset, run, stall, nmi_trigger;
  logic [NI*PW-1:0] irq_period;
  logic [NI-1:0] irq_enable, irq_ack;
  logic cpu_en, sram_en, irq_n, nmi_n;
  logic [31:0] cyc;
  logic [NI-1:0] pend;
  logic cpu_en0, sram_en0, irq_n0, nmi_n0;
  logic [31:0] cyc0;
  logic [NI-1:0] pend0;
`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
  logic step_mode, step;
`endif

  int errors = 0;
  int checks = 0;

  cpu_phase_sequencer #(.MEM_WAIT_STATES(MWS), .NUM_IRQ(NI), .PERIOD_W(PW), .CYCLE_W(32),
                        .NMI_LOW_CYCLES(NMI_LOW)) u_dut (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .irq_period(irq_period),
    .irq_enable(irq_enable), .irq_ack(irq_ack), .nmi_trigger(nmi_trigger),
`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .enable_cpu_clk(cpu_en), .enable_sram_clk(sram_en), .cycle_count(cyc),
    .irq_pending(pend), .irq_n(irq_n), .nmi_n(nmi_n));

  cpu_phase_sequencer #(.MEM_WAIT_STATES(0), .NUM_IRQ(NI), .PERIOD_W(PW), .CYCLE_W(32),
                        .NMI_LOW_CYCLES(NMI_LOW)) u_dut0 (
    .clk(clk), .reset(reset), .run(run), .stall(stall), .irq_period(irq_period),
    .irq_enable(irq_enable), .irq_ack(irq_ack), .nmi_trigger(nmi_trigger),
`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .enable_cpu_clk(cpu_en0), .enable_sram_clk(sram_en0), .cycle_count(cyc0),
    .irq_pending(pend0), .irq_n(irq_n0), .nmi_n(nmi_n0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model for the MEM_WAIT_STATES=2 instance, stated as phase-pair rules.
  bit          m_cpu_next, m_mem;
  int          m_gap;
  logic [31:0] m_cycles;
  int          m_cnt [NI];
  logic [NI-1:0] m_pend;
  bit          m_irq_n;
  int          m_nmi;
  bit          m_trig_prev;

  task automatic model_reset();
    m_cpu_next = 0; m_mem = 0; m_gap = 0; m_cycles = '0;
    for (int i = 0; i < NI; i++) m_cnt[i] = 0;
    m_pend = '0; m_irq_n = 1; m_nmi = 0; m_trig_prev = 0;
  endtask

  task automatic model_step();
    bit cpu;
    bit [NI-1:0] fire;
    int per;
    cpu  = m_cpu_next;
    fire = '0;
    for (int i = 0; i < NI; i++) begin
      per = int'(irq_period[i*PW +: PW]);
      if (!irq_enable[i]) m_cnt[i] = 0;
      else if (cpu && per != 0) begin
        if (m_cnt[i] == per - 1) begin fire[i] = 1; m_cnt[i] = 0; end
        else m_cnt[i] = (m_cnt[i] + 1) % (1 << PW);
      end
    end
    m_irq_n = (m_pend == '0);
    m_pend  = fire | (m_pend & ~irq_ack);
    if (nmi_trigger && !m_trig_prev && m_nmi == 0) m_nmi = NMI_LOW;
    else if (cpu && m_nmi > 0) m_nmi--;
    m_trig_prev = nmi_trigger;
    if (cpu) m_cycles++;
    if (m_cpu_next) begin
      m_cpu_next = 0;
      if (MWS > 0) m_gap = MWS; else m_mem = 1;
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) m_mem = 1;
    end else if (m_mem) begin
      if (!stall) begin m_mem = 0; m_cpu_next = run; end
    end else begin
      m_cpu_next = run;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    run = 0; stall = 0; irq_period = '0; irq_enable = '0; irq_ack = '0; nmi_trigger = 0;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if ({cpu_en, sram_en} !== 2'b00) begin errors++; $display("FAIL reset_enables got=%b exp=00", {cpu_en, sram_en}); end
    checks++; if (cyc !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%0d exp=0", cyc); end
    checks++; if (pend !== '0) begin errors++; $display("FAIL reset_pending got=%b exp=00", pend); end
    checks++; if ({irq_n, nmi_n} !== 2'b11) begin errors++; $display("FAIL reset_irq_nmi got=%b exp=11", {irq_n, nmi_n}); end
  endtask

  task automatic test_nominal();
    run = 1; stall = 0;
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k < 20) begin
        checks++;
        if (cpu_en0 !== 1'(k % 2 == 0)) begin errors++; $display("FAIL nominal_cpu k=%0d got=%b exp=%b", k, cpu_en0, k % 2 == 0); end
        checks++;
        if (sram_en0 !== 1'(k % 2 == 1)) begin errors++; $display("FAIL nominal_sram k=%0d got=%b exp=%b", k, sram_en0, k % 2 == 1); end
      end else begin
        checks++;
        if (cyc0 !== 32'd10) begin errors++; $display("FAIL nominal_cycles got=%0d exp=10", cyc0); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wait_stall();
    int cpu_k[$];
    bit exp_c, exp_s;
    run = 1; stall = 0;
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 14; k++) begin
      stall = (k >= 7 && k <= 9);
      @(negedge clk);
      exp_c = (k == 0 || k == 4 || k == 11);
      exp_s = (k == 3 || k == 10 || k == 14);
      if (cpu_en) cpu_k.push_back(k);
      checks++;
      if (cpu_en !== exp_c) begin errors++; $display("FAIL wait_cpu k=%0d got=%b exp=%b", k, cpu_en, exp_c); end
      checks++;
      if (sram_en !== exp_s) begin errors++; $display("FAIL wait_sram k=%0d got=%b exp=%b", k, sram_en, exp_s); end
      @(posedge clk); #1;
    end
    stall = 0;
    checks++;
    if (cpu_k.size() != 3 || cpu_k[2] - cpu_k[1] != 7)
      begin errors++; $display("FAIL wait_gap got_phases=%0d exp_gap=7", cpu_k.size()); end
  endtask

  task automatic test_irq();
    run = 1; stall = 0; irq_period = {16'd0, 16'd5}; irq_enable = 2'b01; irq_ack = '0;
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 40; k++) begin
      irq_ack = (k == 36 || k == 38) ? 2'b01 : 2'b00;
      @(negedge clk);
      case (k)
        16: begin checks++; if (pend[0] !== 1'b0) begin errors++; $display("FAIL irq_before got=%b exp=0", pend[0]); end end
        17: begin
          checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", pend[0]); end
          checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_n_lag got=%b exp=1", irq_n); end
        end
        18: begin checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_n_fall got=%b exp=0", irq_n); end end
        37: begin checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%b exp=1", pend[0]); end end
        38: begin checks++; if (pend[0] !== 1'b1) begin errors++; $display("FAIL irq_hold got=%b exp=1", pend[0]); end end
        39: begin checks++; if (pend[0] !== 1'b0) begin errors++; $display("FAIL irq_ack got=%b exp=0", pend[0]); end end
        40: begin checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_n_rise got=%b exp=1", irq_n); end end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    irq_ack = '0; irq_enable = '0; irq_period = '0;
  endtask

  task automatic test_nmi();
    int low_phases = 0;
    run = 1; stall = 0; nmi_trigger = 0;
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 27; k++) begin
      nmi_trigger = (k == 9 || k == 17);
      @(negedge clk);
      if (k == 9 || k == 17) begin
        checks++;
        if (cyc !== ((k == 9) ? 32'd3 : 32'd5)) begin errors++; $display("FAIL nmi_cycle k=%0d got=%0d", k, cyc); end
      end
      checks++;
      if (nmi_n !== 1'(!(k >= 10 && k <= 24))) begin errors++; $display("FAIL nmi_level k=%0d got=%b exp=%b", k, nmi_n, !(k >= 10 && k <= 24)); end
      if (cpu_en && !nmi_n) low_phases++;
      @(posedge clk); #1;
    end
    nmi_trigger = 0;
    checks++;
    if (low_phases != NMI_LOW) begin errors++; $display("FAIL nmi_phases got=%0d exp=%0d", low_phases, NMI_LOW); end
  endtask

  task automatic test_run_drop();
    bit exp_c, exp_s;
    run = 1; stall = 0;
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k <= 12; k++) begin
      run = (k < 4);
      @(negedge clk);
      exp_c = (k == 0 || k == 4);
      exp_s = (k == 3 || k == 7);
      checks++;
      if ({cpu_en, sram_en} !== {exp_c, exp_s}) begin errors++; $display("FAIL run_drop k=%0d got=%b exp=%b", k, {cpu_en, sram_en}, {exp_c, exp_s}); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    run = 1; stall = 0; nmi_trigger = 0;
    do_reset();
    @(posedge clk); #1;
    nmi_trigger = 1;
    @(posedge clk); #1;
    checks++; if ({cyc, nmi_n} !== {32'd1, 1'b0}) begin errors++; $display("FAIL pre_reset got=%0d/%b exp=1/0", cyc, nmi_n); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cpu_en, sram_en, irq_n, nmi_n} !== 4'b0011) begin errors++; $display("FAIL async_reset_flags got=%b exp=0011", {cpu_en, sram_en, irq_n, nmi_n}); end
    checks++; if (cyc !== 32'd0) begin errors++; $display("FAIL async_reset_cycle got=%0d exp=0", cyc); end
    nmi_trigger = 0;
    #2 reset = 1'b0;
  endtask

  task automatic test_random();
    run = 1; stall = 0; irq_ack = '0; nmi_trigger = 0;
    irq_period = {16'($urandom_range(1, 7)), 16'($urandom_range(1, 7))};
    irq_enable = 2'b11;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      checks++;
      if (cpu_en !== m_cpu_next) begin errors++; $display("FAIL rnd_cpu n=%0d got=%b exp=%b", n, cpu_en, m_cpu_next); end
      checks++;
      if (sram_en !== 1'(m_mem && !stall)) begin errors++; $display("FAIL rnd_sram n=%0d got=%b exp=%b", n, sram_en, m_mem && !stall); end
      checks++;
      if (cyc !== m_cycles) begin errors++; $display("FAIL rnd_cycles n=%0d got=%0d exp=%0d", n, cyc, m_cycles); end
      checks++;
      if ({pend, irq_n} !== {m_pend, m_irq_n}) begin errors++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, {pend, irq_n}, {m_pend, m_irq_n}); end
      checks++;
      if (nmi_n !== 1'(m_nmi == 0)) begin errors++; $display("FAIL rnd_nmi n=%0d got=%b exp=%b", n, nmi_n, m_nmi == 0); end
      model_step();
      @(posedge clk); #1;
      stall       = ($urandom_range(0, 3) == 0);
      run         = ($urandom_range(0, 15) != 0);
      irq_ack     = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      nmi_trigger = ($urandom_range(0, 7) == 0);
      if (n % 150 == 75) begin
        irq_period = {16'($urandom_range(0, 7)), 16'($urandom_range(1, 7))};
        irq_enable = 2'($urandom_range(0, 3));
      end
    end
    stall = 0; irq_ack = '0; nmi_trigger = 0; irq_enable = '0;
  endtask

`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
  task automatic test_single_step();
    int srams = 0;
    run = 0; stall = 0; step_mode = 1; step = 0;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      step = (k == 5 || k == 7 || k == 20 || k == 35);
      @(negedge clk);
      if (sram_en) srams++;
      @(posedge clk); #1;
    end
    step = 0;
    checks++; if (cyc !== 32'd3) begin errors++; $display("FAIL step_cycles got=%0d exp=3", cyc); end
    checks++; if (srams != 3) begin errors++; $display("FAIL step_srams got=%0d exp=3", srams); end
    step_mode = 0;
  endtask
`endif

  initial begin
`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
    step_mode = 0; step = 0;
`endif
    test_reset();
    test_nominal();
    test_wait_stall();
    test_irq();
    test_nmi();
    test_run_drop();
    test_reset_mid_wait();
    test_random();
`ifdef CPU_PHASE_SEQUENCER_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
